// File: rtl/barker_spreader_tx.sv
// barker_spreader_tx: Barker-11 spreader, one AXI-Stream data bit in, 11 chips out (MSB first); BARKER_TX_TLAST_EVERY_EN flags chip 10 of every symbol
module barker_spreader_tx #(
  parameter logic [10:0] BARKER_SEQ = 11'b11100010010,
  parameter int GAP_CYCLES = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic s_tdata,
  input  logic s_tvalid,
  input  logic s_tlast,
  output logic s_tready,
  output logic m_tdata,
  output logic m_tvalid,
  output logic m_tlast,
  input  logic m_tready
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  localparam logic [3:0] GAP_N = 4'(GAP_CYCLES);
  localparam logic HAS_GAP = GAP_CYCLES != 0;
`ifdef BARKER_TX_TLAST_EVERY_EN
  localparam logic TLAST_EVERY = 1'b1;
`else
  localparam logic TLAST_EVERY = 1'b0;
`endif
  state_t state_q, state_d;
  logic [10:0] chip_sr_q, chip_sr_d;
  logic [3:0] chip_idx_q, chip_idx_d, gap_cnt_q, gap_cnt_d;
  logic last_q, last_d;
  logic send, chip_end, accept;
  assign send = state_q == SEND;
  assign chip_end = send && chip_idx_q == 4'd10;
  assign m_tvalid = send;
  assign m_tdata = send & chip_sr_q[10];
  assign m_tlast = chip_end & (last_q | TLAST_EVERY);
  assign s_tready = i_rst_n & (state_q == IDLE || (chip_end && m_tready && !HAS_GAP));
  assign accept = s_tvalid & s_tready;
  always_comb begin
    state_d = state_q;
    chip_sr_d = chip_sr_q;
    chip_idx_d = chip_idx_q;
    gap_cnt_d = gap_cnt_q;
    last_d = last_q;
    if (send && m_tready) begin
      if (!chip_end) begin
        chip_sr_d = {chip_sr_q[9:0], 1'b0};
        chip_idx_d = chip_idx_q + 4'd1;
      end else begin
        state_d = HAS_GAP ? GAP : IDLE;
        gap_cnt_d = GAP_N;
      end
    end
    if (state_q == GAP) begin
      gap_cnt_d = gap_cnt_q - 4'd1;
      state_d = gap_cnt_q <= 4'd1 ? IDLE : GAP;
    end
    if (accept) begin
      chip_sr_d = BARKER_SEQ ^ {11{~s_tdata}};
      chip_idx_d = 4'd0;
      last_d = s_tlast;
      state_d = SEND;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      chip_sr_q <= '0;
      chip_idx_q <= '0;
      gap_cnt_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chip_sr_q <= chip_sr_d;
      chip_idx_q <= chip_idx_d;
      gap_cnt_q <= gap_cnt_d;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_barker_spreader_tx.sv
// tb_barker_spreader_tx: randomized check of two spreaders (no gap, gap of 3) against a symbol-level model
module tb_barker_spreader_tx;
  localparam logic [10:0] SEQ = 11'b11100010010;
  logic clk = 1'b0;
  logic rst_n, s_tdata, s_tvalid, s_tlast, m_tready;
  logic [1:0] s_rdy, m_dat, m_vld, m_lst;
  int checks = 0, failures = 0;
  bit act[2], dat[2], lst[2], rdy_exp[2];
  int pos[2], gap[2];
  int gaps[2] = '{0, 3};
  always #5 clk = ~clk;
  barker_spreader_tx #(.BARKER_SEQ(SEQ), .GAP_CYCLES(0)) u_g0 (
    .i_clk(clk), .i_rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_rdy[0]), .m_tdata(m_dat[0]), .m_tvalid(m_vld[0]), .m_tlast(m_lst[0]), .m_tready(m_tready));
  barker_spreader_tx #(.BARKER_SEQ(SEQ), .GAP_CYCLES(3)) u_g3 (
    .i_clk(clk), .i_rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_rdy[1]), .m_tdata(m_dat[1]), .m_tvalid(m_vld[1]), .m_tlast(m_lst[1]), .m_tready(m_tready));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit chip(input bit d, input int p);
    logic [10:0] s;
    s = SEQ;
    return s[10 - p] ^ ~d;
  endfunction
  task automatic step(input bit r, input bit v, input bit d, input bit l, input bit mr);
    bit every;
`ifdef BARKER_TX_TLAST_EVERY_EN
    every = 1'b1;
`else
    every = 1'b0;
`endif
    @(negedge clk);
    rst_n = r; s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = mr;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy_exp[k] = r && ((!act[k] && gap[k] == 0) || (act[k] && pos[k] == 10 && mr && gaps[k] == 0));
      check($sformatf("m_tvalid[%0d]", k), 32'(m_vld[k]), 32'(act[k]));
      check($sformatf("m_tdata[%0d]", k), 32'(m_dat[k]), 32'(act[k] && chip(dat[k], pos[k])));
      check($sformatf("m_tlast[%0d]", k), 32'(m_lst[k]), 32'(act[k] && pos[k] == 10 && (lst[k] || every)));
      check($sformatf("s_tready[%0d]", k), 32'(s_rdy[k]), 32'(rdy_exp[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        act[k] = 0; gap[k] = 0; pos[k] = 0;
      end else begin
        if (gap[k] > 0) gap[k]--;
        if (act[k] && mr) begin
          if (pos[k] < 10) pos[k]++;
          else begin
            act[k] = 0;
            gap[k] = gaps[k];
          end
        end
        if (rdy_exp[k] && v) begin
          act[k] = 1; pos[k] = 0; dat[k] = d; lst[k] = l;
        end
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      act[k] = 0; pos[k] = 0; gap[k] = 0; dat[k] = 0; lst[k] = 0;
    end
    rst_n = 0; s_tvalid = 0; s_tdata = 0; s_tlast = 0; m_tready = 0;
    repeat (3) step(0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 1);
    repeat (14) step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    repeat (14) step(1, 0, 0, 0, 1);
    for (int i = 0; i < 60; i++) step(1, 1, i % 4 != 1, i >= 33, 1);
    repeat (16) step(1, 0, 0, 0, 1);
    step(1, 1, 1, 0, 1);
    repeat (4) step(1, 0, 0, 0, 1);
    repeat (5) step(1, 1, 0, 1, 0);
    repeat (12) step(1, 0, 0, 0, 1);
    step(1, 1, 1, 1, 1);
    repeat (6) step(1, 0, 0, 0, 1);
    step(0, 1, 1, 1, 1);
    step(1, 0, 0, 0, 1);
    step(1, 1, 1, 1, 1);
    repeat (14) step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
